vend_dispense_sequencer: RTL
============================

# vend_dispense_sequencer

Sequences the physical vend after the vending FSM has settled a purchase. It pulses the selected product motor and confirms the drop via the drop sensor. It then pays change, or refunds the full credit on a jam or cancel, coin by coin from the value-1 and value-2 hoppers. It sits between the vending FSM (request side) and the motor/hopper drivers (actuator side).

## Interface
- PULSE_CYCLES, 4: width of every motor/hopper drive pulse, in clk cycles (≥1)
- GAP_CYCLES, 2: idle cycles after each hopper pulse (≥1)
- DROP_TIMEOUT, 16: cycles allowed in WAIT_DROP before declaring a jam (≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  vend/refund request
- req_ready  out  1  high only in IDLE
- req_refund  in  1  1 = no product; pay req_credit
- req_item  in  2  product index 0..3
- req_change  in  3  coin units owed after a successful vend
- req_credit  in  3  total units inserted (jam/refund payout)
- motor  out  4  one-hot motor drive
- drop_sense  in  1  product drop sensor, level
- hop1_fire, hop2_fire  out  1 each  hopper drive for value-1 / value-2 coin
- hop1_empty, hop2_empty  in  1 each  hopper empty flags
- done_valid  out  1  one-cycle completion pulse
- done_status  out  2  00 OK, 01 JAM, 10 SHORT (unpaid balance), 11 REFUND_OK
- done_owed  out  3  units not paid out (0 unless SHORT)

## Operation
- States: IDLE, MOTOR, WAIT_DROP, COIN_SEL, COIN_PULSE, COIN_GAP, DONE.
- IDLE: on req_valid&req_ready, latch item, change, credit and refund. Refund goes to COIN_SEL with remaining=credit. Otherwise go to MOTOR with remaining=change.
- MOTOR: motor[item]=1 for PULSE_CYCLES, then WAIT_DROP.
- drop_sense is sampled in MOTOR and WAIT_DROP. Any high sample sets a sticky dropped flag.
- WAIT_DROP: if dropped, go to COIN_SEL. If DROP_TIMEOUT cycles elapse without a drop, set jam, set remaining=credit, and go to COIN_SEL.
- COIN_SEL greedy rule, checked in order, one cycle:
  - remaining≥2 and !hop2_empty: fire hop2 and subtract 2.
  - else remaining≥1 and !hop1_empty: fire hop1 and subtract 1.
  - else remaining==0: go to DONE.
  - else: SHORT, go to DONE.
- Never overpay: remaining=1 with hop1 empty is SHORT even if hop2 has coins.
- COIN_PULSE: the selected hop*_fire is high for PULSE_CYCLES. COIN_GAP: GAP_CYCLES low, then back to COIN_SEL.
- DONE: done_valid=1 for one cycle, then IDLE. Status priority: SHORT > JAM > REFUND_OK > OK.
- Arithmetic: remaining is 3-bit unsigned. A subtract happens only when the guard holds, so remaining cannot wrap.
- Requests are ignored outside IDLE. req_valid held high is accepted again one cycle after DONE.

## Timing
- Reset (async assert, sync deassert): state IDLE, remaining 0, flags 0.
- Outputs during reset: req_ready=1, motor=0, hop1_fire=hop2_fire=0, done_valid=0, done_status=00, done_owed=0.
- Reset mid-pulse: drives drop within the same reset assertion. The latched request is discarded.
- Acceptance at edge E: motor is high in cycles E+1..E+PULSE_CYCLES.
- Each coin costs 1+PULSE_CYCLES+GAP_CYCLES cycles. A DONE with zero coins follows COIN_SEL by one cycle.
- Hopper-empty flags are sampled only in COIN_SEL. A flag changing mid-pulse does not abort the pulse.
- Only one of motor, hop1_fire, hop2_fire is ever active in a given cycle.
- done_status and done_owed are valid only while done_valid=1. They are 0 otherwise.

## Structure
- Shared package vend_pkg:
  - state enum
  - status codes
  - coin value constants (COIN1=1, COIN2=2)
  - item index width
- Sub-module vend_pulse_timer: loadable down-counter with a load value and a zero flag. It serves the motor pulse, hopper pulse, gap, and drop timeout (width from max of parameters).

## Test plan
- Item 0, change=3, drop_sense 2 cycles into WAIT_DROP, hoppers full -> 1×hop2 then 1×hop1 pulse of 4 cycles each; done_status=00, owed=0.
- Item 2, change=0, drop during MOTOR -> motor[2] exactly 4 cycles, no hopper pulses, done in COIN_SEL+1.
- Item 1, credit=5, drop_sense never high -> after 16 WAIT_DROP cycles 2×hop2 + 1×hop1; status=01.
- Refund, credit=3, hop2_empty=1 -> 3×hop1 pulses; status=11.
- change=3, hop1_empty=1 -> 1×hop2 pulse then SHORT, done_owed=1.
- rst low during second hopper pulse -> hop2_fire drops immediately, req_ready=1; a new request after release completes normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vend dispense sequencer.
//   state_t  : sequencer FSM states
//   status_t : completion status codes reported on done_status
//   COIN1/2  : coin values of the two hoppers, in coin units
//   ITEM_W   : width of the product index, NUM_ITEMS motors
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOTOR,
        ST_WAIT_DROP,
        ST_COIN_SEL,
        ST_COIN_PULSE,
        ST_COIN_GAP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        STAT_OK        = 2'b00,
        STAT_JAM       = 2'b01,
        STAT_SHORT     = 2'b10,
        STAT_REFUND_OK = 2'b11
    } status_t;

    localparam logic [2:0] COIN1 = 3'd1;
    localparam logic [2:0] COIN2 = 3'd2;

    localparam int ITEM_W    = 2;
    localparam int NUM_ITEMS = 1 << ITEM_W;

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter used for every timed interval of the sequencer
// (motor pulse, hopper pulse, inter-coin gap, drop timeout).
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_val this cycle (wins over counting)
//   load_val  : interval length minus one
//   zero      : counter has reached zero (last cycle of the interval)
module vend_pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Physical vend sequencer: pulses the selected product motor, confirms the
// drop, then pays change (or refunds full credit on jam/cancel) coin by coin
// from the value-2 and value-1 hoppers using a greedy, never-overpay rule.
//   clk, rst                 : clock, asynchronous active-low reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_refund, req_item,
//   req_change, req_credit   : request payload
//   motor                    : one-hot product motor drive
//   drop_sense               : product drop sensor (level)
//   hop1_fire, hop2_fire     : hopper drives, hop*_empty: hopper empty flags
//   done_valid/status/owed   : one-cycle completion report
module vend_dispense_sequencer
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int DROP_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_refund,
    input  logic [ITEM_W-1:0]    req_item,
    input  logic [2:0]           req_change,
    input  logic [2:0]           req_credit,
    output logic [NUM_ITEMS-1:0] motor,
    input  logic                 drop_sense,
    output logic                 hop1_fire,
    output logic                 hop2_fire,
    input  logic                 hop1_empty,
    input  logic                 hop2_empty,
    output logic                 done_valid,
    output logic [1:0]           done_status,
    output logic [2:0]           done_owed
);

    // Timer holds interval-1, so it needs enough bits for the longest interval-1.
    localparam int MAX_A    = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int MAX_LOAD = (MAX_A > DROP_TIMEOUT) ? MAX_A : DROP_TIMEOUT;
    localparam int TW       = (MAX_LOAD < 2) ? 1 : $clog2(MAX_LOAD);

    localparam logic [TW-1:0] LD_PULSE   = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] LD_GAP     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] LD_TIMEOUT = TW'(DROP_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ITEM_W-1:0] item_q, item_d;
    logic [2:0]        remaining_q, remaining_d;
    logic [2:0]        credit_q, credit_d;
    logic              refund_q, refund_d;
    logic              dropped_q, dropped_d;
    logic              jam_q, jam_d;
    logic              short_q, short_d;
    logic              sel2_q, sel2_d;     // current coin pulse drives hop2

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_zero;

    vend_pulse_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        item_d      = item_q;
        remaining_d = remaining_q;
        credit_d    = credit_q;
        refund_d    = refund_q;
        dropped_d   = dropped_q;
        jam_d       = jam_q;
        short_d     = short_q;
        sel2_d      = sel2_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    item_d    = req_item;
                    credit_d  = req_credit;
                    refund_d  = req_refund;
                    dropped_d = 1'b0;
                    jam_d     = 1'b0;
                    short_d   = 1'b0;
                    sel2_d    = 1'b0;
                    if (req_refund) begin
                        remaining_d = req_credit;
                        state_d     = ST_COIN_SEL;
                    end else begin
                        remaining_d = req_change;
                        state_d     = ST_MOTOR;
                        tmr_load    = 1'b1;
                        tmr_val     = LD_PULSE;
                    end
                end
            end
            ST_MOTOR: begin
                dropped_d = dropped_q | drop_sense;
                if (tmr_zero) begin
                    state_d  = ST_WAIT_DROP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_TIMEOUT;
                end
            end
            ST_WAIT_DROP: begin
                dropped_d = dropped_q | drop_sense;
                // A drop seen on the final timeout cycle still counts as a vend.
                if (dropped_q || drop_sense) begin
                    state_d = ST_COIN_SEL;
                end else if (tmr_zero) begin
                    jam_d       = 1'b1;
                    remaining_d = credit_q;
                    state_d     = ST_COIN_SEL;
                end
            end
            ST_COIN_SEL: begin
                if (remaining_q >= COIN2 && !hop2_empty) begin
                    remaining_d = remaining_q - COIN2;
                    sel2_d      = 1'b1;
                    state_d     = ST_COIN_PULSE;
                    tmr_load    = 1'b1;
                    tmr_val     = LD_PULSE;
                end else if (remaining_q >= COIN1 && !hop1_empty) begin
                    remaining_d = remaining_q - COIN1;
                    sel2_d      = 1'b0;
                    state_d     = ST_COIN_PULSE;
                    tmr_load    = 1'b1;
                    tmr_val     = LD_PULSE;
                end else begin
                    // Balance left but no hopper can pay it without overpaying.
                    if (remaining_q != 3'd0) begin
                        short_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_COIN_PULSE: begin
                if (tmr_zero) begin
                    state_d  = ST_COIN_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GAP;
                end
            end
            ST_COIN_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_COIN_SEL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        motor       = '0;
        hop1_fire   = 1'b0;
        hop2_fire   = 1'b0;
        done_valid  = 1'b0;
        done_status = STAT_OK;
        done_owed   = 3'd0;

        if (state_q == ST_MOTOR) begin
            motor[item_q] = 1'b1;
        end
        if (state_q == ST_COIN_PULSE) begin
            hop2_fire = sel2_q;
            hop1_fire = !sel2_q;
        end
        if (state_q == ST_DONE) begin
            done_valid = 1'b1;
            if (short_q) begin
                done_status = STAT_SHORT;
                done_owed   = remaining_q;
            end else if (jam_q) begin
                done_status = STAT_JAM;
            end else if (refund_q) begin
                done_status = STAT_REFUND_OK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            item_q      <= '0;
            remaining_q <= 3'd0;
            credit_q    <= 3'd0;
            refund_q    <= 1'b0;
            dropped_q   <= 1'b0;
            jam_q       <= 1'b0;
            short_q     <= 1'b0;
            sel2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            item_q      <= item_d;
            remaining_q <= remaining_d;
            credit_q    <= credit_d;
            refund_q    <= refund_d;
            dropped_q   <= dropped_d;
            jam_q       <= jam_d;
            short_q     <= short_d;
            sel2_q      <= sel2_d;
        end
    end

endmodule
